// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined signed W x W multiplier among NREQ requesters.
// Products come back tagged with the issuing requester's index, in issue order.
module mult_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int MULT_LAT = 2
) (
    input  logic                      clk100,
    input  logic                      reset,
    input  logic [NREQ-1:0]           en_mask,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*W-1:0]         req_a,
    input  logic [NREQ*W-1:0]         req_b,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*W-1:0]            rsp_prod,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]          rr_ptr;
    logic [NREQ-1:0]         eligible;
    logic [NREQ-1:0]         grant;
    logic                    found;
    logic                    transfer;
    logic [IDW-1:0]          win_id;
    logic [W-1:0]            win_a;
    logic [W-1:0]            win_b;
    int                      idx;

    logic                    s0_valid;
    logic [IDW-1:0]          s0_id;
    logic [W-1:0]            s0_a;
    logic [W-1:0]            s0_b;
    logic signed [2*W-1:0]   ext_a;
    logic signed [2*W-1:0]   ext_b;
    logic signed [2*W-1:0]   prod0;

    assign eligible = req_valid & en_mask;

    // Scan starting at rr_ptr and wrapping; the first eligible index wins.
    always_comb begin
        grant  = '0;
        win_id = '0;
        win_a  = '0;
        win_b  = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_id     = IDW'(idx);
                win_a      = req_a[idx*W +: W];
                win_b      = req_b[idx*W +: W];
            end
        end
        if (reset) begin
            grant = '0;
        end
    end

    assign req_ready = grant;
    assign transfer  = |grant;

    // Operand registers only load on a transfer so the product output holds between pulses.
    always_ff @(posedge clk100) begin
        if (reset) begin
            rr_ptr   <= '0;
            s0_valid <= 1'b0;
            s0_id    <= '0;
            s0_a     <= '0;
            s0_b     <= '0;
        end else begin
            s0_valid <= transfer;
            if (transfer) begin
                s0_id  <= win_id;
                s0_a   <= win_a;
                s0_b   <= win_b;
                rr_ptr <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
            end
        end
    end

    assign ext_a = {{W{s0_a[W-1]}}, s0_a};
    assign ext_b = {{W{s0_b[W-1]}}, s0_b};
    assign prod0 = ext_a * ext_b;

    generate
        if (MULT_LAT == 1) begin : g_lat1
            assign rsp_valid = s0_valid;
            assign rsp_id    = s0_id;
            assign rsp_prod  = prod0;
            assign busy      = s0_valid;
        end else begin : g_latn
            logic [MULT_LAT-2:0]  tv;
            logic [IDW-1:0]       ti [MULT_LAT-1];
            logic [2*W-1:0]       tp [MULT_LAT-1];

            always_ff @(posedge clk100) begin
                if (reset) begin
                    tv <= '0;
                    for (int j = 0; j < MULT_LAT-1; j++) begin
                        ti[j] <= '0;
                        tp[j] <= '0;
                    end
                end else begin
                    tv[0] <= s0_valid;
                    if (s0_valid) begin
                        ti[0] <= s0_id;
                        tp[0] <= prod0;
                    end
                    for (int j = 1; j < MULT_LAT-1; j++) begin
                        tv[j] <= tv[j-1];
                        if (tv[j-1]) begin
                            ti[j] <= ti[j-1];
                            tp[j] <= tp[j-1];
                        end
                    end
                end
            end

            assign rsp_valid = tv[MULT_LAT-2];
            assign rsp_id    = ti[MULT_LAT-2];
            assign rsp_prod  = tp[MULT_LAT-2];
            assign busy      = s0_valid | (|tv);
        end
    endgenerate

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: grants are checked as they are issued, products
// are queued with their due cycle and checked by an independent response monitor.
module tb_mult_share_arbiter;

    localparam int NREQ     = 4;
    localparam int W        = 8;
    localparam int MULT_LAT = 2;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] prod;
        int          due;
    } exp_t;

    logic               clk100 = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    en_mask = '0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*W-1:0]  req_a = '0;
    logic [NREQ*W-1:0]  req_b = '0;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [15:0]        rsp_prod;
    logic               busy;

    logic signed [W-1:0] a_val [NREQ];
    logic signed [W-1:0] b_val [NREQ];

    exp_t  sb_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    mult_share_arbiter #(.NREQ(NREQ), .W(W), .MULT_LAT(MULT_LAT)) dut (
        .clk100    (clk100),
        .reset     (reset),
        .en_mask   (en_mask),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bench cycle: drive after the edge, check the grant at the falling edge,
    // and queue the hand-computed product if a transfer is expected.
    task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic [3:0] mask,
                                 input logic [3:0] exp_grant, input logic [15:0] exp_prod,
                                 input bit push);
        exp_t e;
        @(posedge clk100);
        #1;
        reset     = rst;
        req_valid = valid;
        en_mask   = mask;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a_val[i];
            req_b[i*W +: W] = b_val[i];
        end
        @(negedge clk100);
        checkOutput("req_ready", {28'd0, req_ready}, {28'd0, exp_grant});
        if (push && exp_grant != 4'b0000) begin
            e.id = 2'd0;
            for (int i = 0; i < NREQ; i++) begin
                if (exp_grant[i]) e.id = 2'(i);
            end
            e.prod = exp_prod;
            e.due  = cyc + MULT_LAT;
            sb_q.push_back(e);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'b0000, 4'b1111, 4'b0000, 16'h0000, 1'b0);
    endtask

    task automatic setStdOperands();
        a_val[0] = 8'sd2;   b_val[0] = 8'sd3;
        a_val[1] = -8'sd4;  b_val[1] = 8'sd5;
        a_val[2] = 8'sd7;   b_val[2] = -8'sd7;
        a_val[3] = -8'sd10; b_val[3] = -8'sd12;
    endtask

    // Response monitor: flags overdue, unexpected or wrong products.
    always @(negedge clk100) begin
        if (!reset) begin
            while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL missing_rsp: got none expected id %0d prod %0h due cycle %0d",
                         sb_q[0].id, sb_q[0].prod, sb_q[0].due);
                void'(sb_q.pop_front());
            end
            if (rsp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_rsp: got id %0d prod %0h expected no response",
                             rsp_id, rsp_prod);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
                    checkOutput("rsp_prod", {16'd0, rsp_prod}, {16'd0, e.prod});
                    checkOutput("rsp_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        setStdOperands();

        // Reset: no grants while reset is high, outputs cleared afterwards
        applyStimulus(1'b1, 4'b1111, 4'b1111, 4'b0000, 16'h0000, 1'b0);
        applyStimulus(1'b1, 4'b1111, 4'b1111, 4'b0000, 16'h0000, 1'b0);
        idleCycle();
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
        checkOutput("reset_rsp_prod", {16'd0, rsp_prod}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);

        // Single request from requester 2, busy for exactly two cycles
        a_val[2] = 8'sd3; b_val[2] = 8'sd5;
        applyStimulus(1'b0, 4'b0100, 4'b1111, 4'b0100, 16'h000F, 1'b1);
        idleCycle();
        checkOutput("busy_t1_c1", {31'd0, busy}, 32'd1);
        idleCycle();
        checkOutput("busy_t1_c2", {31'd0, busy}, 32'd1);
        idleCycle();
        checkOutput("busy_t1_c3", {31'd0, busy}, 32'd0);

        // Signed extremes back-to-back from requester 0
        a_val[0] = -8'sd128; b_val[0] = -8'sd128;
        applyStimulus(1'b0, 4'b0001, 4'b1111, 4'b0001, 16'h4000, 1'b1);
        a_val[0] = 8'sd127;  b_val[0] = -8'sd128;
        applyStimulus(1'b0, 4'b0001, 4'b1111, 4'b0001, 16'hC080, 1'b1);
        a_val[0] = -8'sd1;   b_val[0] = -8'sd1;
        applyStimulus(1'b0, 4'b0001, 4'b1111, 4'b0001, 16'h0001, 1'b1);
        for (int i = 0; i < 3; i++) idleCycle();

        // Park the pointer at 0 via requester 3, then full rotation for 8 cycles
        setStdOperands();
        applyStimulus(1'b0, 4'b1000, 4'b1111, 4'b1000, 16'h0078, 1'b1);
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b0001, 16'h0006, 1'b1);
            applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b0010, 16'hFFEC, 1'b1);
            applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b0100, 16'hFFCF, 1'b1);
            applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b1000, 16'h0078, 1'b1);
        end

        // Pointer at 3 with requesters 0 and 3 eligible, then confirm pointer at 1
        applyStimulus(1'b0, 4'b0100, 4'b1111, 4'b0100, 16'hFFCF, 1'b1);
        applyStimulus(1'b0, 4'b1001, 4'b1111, 4'b1000, 16'h0078, 1'b1);
        applyStimulus(1'b0, 4'b0001, 4'b1111, 4'b0001, 16'h0006, 1'b1);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b0010, 16'hFFEC, 1'b1);

        // Requester 0 masked: rotation skips it until the mask bit returns
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1'b0, 4'b1111, 4'b1110, 4'b0100, 16'hFFCF, 1'b1);
            applyStimulus(1'b0, 4'b1111, 4'b1110, 4'b1000, 16'h0078, 1'b1);
            applyStimulus(1'b0, 4'b1111, 4'b1110, 4'b0010, 16'hFFEC, 1'b1);
        end
        applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b0100, 16'hFFCF, 1'b1);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b1000, 16'h0078, 1'b1);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b0001, 16'h0006, 1'b1);

        // Everything masked: no grants and busy drains
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        checkOutput("busy_mask0_c1", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        checkOutput("busy_mask0_c2", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        checkOutput("busy_mask0_c3", {31'd0, busy}, 32'd0);

        // Reset one cycle after a transfer discards it and clears the pointer
        applyStimulus(1'b0, 4'b0010, 4'b1111, 4'b0010, 16'hFFEC, 1'b0);
        applyStimulus(1'b1, 4'b1111, 4'b1111, 4'b0000, 16'h0000, 1'b0);
        idleCycle();
        checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("post_reset_rsp_prod", {16'd0, rsp_prod}, 32'd0);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b0001, 16'h0006, 1'b1);
        for (int i = 0; i < 4; i++) idleCycle();

        checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one pipelined signed W x W multiplier between NREQ requesters using per-requester valid/ready handshakes.
- Sits in the common clk100 domain, in front of the product datapath.
- Board-specific and common logic submit operand pairs here instead of each instantiating a multiplier.
- Returns each product tagged with the requester ID, in issue order.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; product width is 2W.
- MULT_LAT, 2, cycles from accepted request to rsp_valid (1..4).

Ports:
- clk100  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en_mask  input  NREQ  per-requester enable; a 0 bit removes that requester from arbitration.
- req_valid  input  NREQ  requester i has an operand pair pending.
- req_ready  output  NREQ  one-hot grant; combinational from req_valid, en_mask and rr_ptr.
- req_a  input  NREQ*W  packed operand A; slice i belongs to requester i; signed.
- req_b  input  NREQ*W  packed operand B; signed.
- rsp_valid  output  1  one-cycle pulse per completed product.
- rsp_id  output  clog2(NREQ)  index of the requester that issued the product.
- rsp_prod  output  2W  signed product.
- busy  output  1  high while any pipeline stage holds a valid entry.

Behaviour:
- Arbitration:
  - eligible[i] = req_valid[i] & en_mask[i].
  - Winner is the first eligible index scanning rr_ptr, rr_ptr+1, ... with wrap mod NREQ.
  - req_ready is one-hot on the winner, or all-zero if nothing is eligible.
  - At most one transfer per cycle. Transfer = req_valid[i] & req_ready[i].
- Round-robin pointer:
  - On a transfer from requester i, rr_ptr <= (i+1) mod NREQ on the next edge.
  - With no transfer, rr_ptr holds.
  - NREQ-1 wraps to 0.
- Pipeline:
  - Stage 0 registers a, b and id on transfer.
  - Product is computed signed at full 2W width, with no truncation or saturation.
  - MULT_LAT-1 further register stages carry valid, id and product.
  - A transfer at edge k yields rsp_valid=1 during the cycle after edge k+MULT_LAT-1, i.e. MULT_LAT cycles after the accepting cycle.
  - Fully pipelined: back-to-back transfers produce back-to-back rsp_valid pulses.
- No response backpressure: the consumer must accept every rsp_valid.
- When rsp_valid=0, rsp_id and rsp_prod hold their last values (don't-care to consumers).
- Requester rules:
  - Must hold req_a/req_b/req_valid stable until req_ready.
  - Deasserting req_valid before grant is permitted; that request is simply never issued.
- en_mask:
  - Sampled combinationally each cycle.
  - Clearing a bit mid-wait blocks that requester immediately.
  - In-flight products of a disabled requester still complete.
- busy is the OR of all stage valids, excluding the arbitration cycle itself.
- Reset (synchronous, any cycle):
  - rr_ptr=0; all stage valids=0; rsp_valid=0; rsp_id=0; rsp_prod=0; busy=0.
  - In-flight products are discarded with no rsp_valid.
  - req_ready follows combinationally and is all-zero while reset is high.
- Boundaries:
  - All requesters eligible every cycle: grants rotate 0,1,...,NREQ-1,0 with no repeats inside a rotation.
  - A single eligible requester is granted every cycle.
  - en_mask=0 gives no grants, and busy drains to 0 after MULT_LAT cycles.
  - Operand extremes: -2^(W-1) * -2^(W-1) = +2^(2W-2), which fits 2W signed without overflow.

Test Plan:
- Reset, then a single request from requester 2 (a=3, b=5) with MULT_LAT=2 -> req_ready=0b0100 same cycle; rsp_valid 2 cycles later with rsp_id=2, rsp_prod=0x000F; busy high for exactly 2 cycles.
- Signed extremes issued back-to-back from requester 0: (-128,-128), (127,-128), (-1,-1) -> rsp_prod sequence 0x4000, 0xC080, 0x0001 on 3 consecutive rsp_valid cycles, all rsp_id=0.
- All 4 requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_id on the response side repeats the same order with one pulse per cycle.
- rr_ptr=3 with requesters 0 and 3 eligible -> 3 granted first, then 0; rr_ptr ends at 1.
- en_mask=0b1110 with all valid -> requester 0 never granted; grants rotate 1,2,3; setting en_mask[0]=1 -> 0 is granted when the rotation reaches it.
- Reset asserted one cycle after a transfer -> no rsp_valid is ever produced for that request; busy=0 and rr_ptr=0 the cycle after reset.
